// File: rtl/regfile_port_arbiter_pkg.sv
// rtl/regfile_port_arbiter_pkg.sv - shared types and sizes for the regfile port arbiter
package regfile_arb_pkg;
  localparam int NREQ       = 2;
  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 3;

  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } state_t;
endpackage

// File: rtl/regfile_port_arbiter_if.sv
// rtl/regfile_port_arbiter_if.sv - requester, response and regfile signal bundle
interface regfile_port_arbiter_if
  import regfile_arb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);
  logic [NREQ-1:0]        req;
  logic [NREQ-1:0]        req_we;
  logic [NREQ-1:0]        req_lock;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ*DATA_W-1:0] req_wdata;
  logic [NREQ-1:0]        gnt;
  logic [NREQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]      rsp_data;
  logic [DATA_W-1:0]      rf_data_in;
  logic [ADDR_W-1:0]      rf_writenum;
  logic                   rf_write;
  logic [ADDR_W-1:0]      rf_readnum;
  logic [DATA_W-1:0]      rf_data_out;

  // master: requesters plus the regfile read port; slave: the arbiter
  modport master (
    output req, req_we, req_lock, req_addr, req_wdata, rf_data_out,
    input  gnt, rsp_valid, rsp_data, rf_data_in, rf_writenum, rf_write, rf_readnum
  );

  modport slave (
    input  req, req_we, req_lock, req_addr, req_wdata, rf_data_out,
    output gnt, rsp_valid, rsp_data, rf_data_in, rf_writenum, rf_write, rf_readnum
  );
endinterface

// File: rtl/regfile_port_arbiter_rr_pick2.sv
// rtl/regfile_port_arbiter_rr_pick2.sv - combinational 2-way round-robin picker
module rr_pick2 (
  input  logic [1:0] req_i,
  input  logic       rr_ptr_i,
  output logic [1:0] gnt_o
);
  always_comb begin
    gnt_o = req_i;
    if (req_i == 2'b11) begin
      gnt_o = rr_ptr_i ? 2'b10 : 2'b01;
    end
  end
endmodule

// File: rtl/regfile_port_arbiter.sv
// rtl/regfile_port_arbiter.sv - two-requester arbiter for a 1R/1W regfile with lock; REGFILE_ARB_STATS_EN adds grant/stall counters
module regfile_port_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  regfile_port_arbiter_if.slave  bus
`ifdef REGFILE_ARB_STATS_EN
  ,
  output logic [2*16-1:0]        gnt_cnt,
  output logic [2*16-1:0]        stall_cnt
`endif
);
  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic              rr_ptr_q, rr_ptr_d;
  logic [NREQ-1:0]   pick_gnt, gnt_int;
  logic [NREQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_in_q;
  logic              lock_hold, pick_ptr, any_gnt, sel, sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  assign lock_hold = (state_q == LOCK) && bus.req[owner_q] && bus.req_lock[owner_q];
  // The cycle that releases a lock favours the requester that was stalled.
  assign pick_ptr  = (state_q == LOCK) ? ~owner_q : rr_ptr_q;

  rr_pick2 u_pick (
    .req_i    (bus.req),
    .rr_ptr_i (pick_ptr),
    .gnt_o    (pick_gnt)
  );

  always_comb begin
    gnt_int = pick_gnt;
    if (lock_hold) begin
      gnt_int = owner_q ? 2'b10 : 2'b01;
    end
    if (!rst_n) begin
      gnt_int = '0;
    end
  end

  assign any_gnt   = |gnt_int;
  assign sel       = gnt_int[1];
  assign sel_we    = bus.req_we[sel];
  assign sel_addr  = sel ? bus.req_addr[2*ADDR_W-1:ADDR_W]   : bus.req_addr[ADDR_W-1:0];
  assign sel_wdata = sel ? bus.req_wdata[2*DATA_W-1:DATA_W] : bus.req_wdata[DATA_W-1:0];

  always_comb begin
    state_d     = ARB;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    rsp_valid_d = '0;
    if (any_gnt) begin
      rr_ptr_d = ~sel;
      owner_d  = sel;
      if (bus.req_lock[sel]) begin
        state_d = LOCK;
      end
      if (!sel_we) begin
        rsp_valid_d = gnt_int;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ARB;
      owner_q     <= 1'b0;
      rr_ptr_q    <= 1'b0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      addr_q      <= '0;
      data_in_q   <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      rsp_valid_q <= rsp_valid_d;
      if (any_gnt) begin
        addr_q    <= sel_addr;
        data_in_q <= sel_wdata;
      end
      if (any_gnt && !sel_we) begin
        rsp_data_q <= bus.rf_data_out;
      end
    end
  end

  assign bus.gnt         = gnt_int;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_data    = rsp_data_q;
  assign bus.rf_write    = any_gnt & sel_we & rst_n;
  assign bus.rf_writenum = any_gnt ? sel_addr : addr_q;
  assign bus.rf_readnum  = any_gnt ? sel_addr : addr_q;
  assign bus.rf_data_in  = any_gnt ? sel_wdata : data_in_q;

`ifdef REGFILE_ARB_STATS_EN
  logic [NREQ-1:0][15:0] gnt_cnt_q, stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (gnt_int[i] && gnt_cnt_q[i] != 16'hFFFF) begin
          gnt_cnt_q[i] <= gnt_cnt_q[i] + 16'd1;
        end
        if (bus.req[i] && !gnt_int[i] && stall_cnt_q[i] != 16'hFFFF) begin
          stall_cnt_q[i] <= stall_cnt_q[i] + 16'd1;
        end
      end
    end
  end

  assign gnt_cnt   = gnt_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_regfile_port_arbiter.sv
// tb/tb_regfile_port_arbiter.sv - randomized scoreboard bench for regfile_port_arbiter
module tb_regfile_port_arbiter;
  localparam int DW = 16;
  localparam int AW = 3;

  typedef struct {
    int          cyc;
    logic [15:0] data;
  } rsp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  regfile_port_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

`ifdef REGFILE_ARB_STATS_EN
  logic [31:0] gnt_cnt_w, stall_cnt_w;
  regfile_port_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave), .gnt_cnt(gnt_cnt_w), .stall_cnt(stall_cnt_w));
`else
  regfile_port_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave));
`endif

  // Regfile the arbiter drives: synchronous write, combinational read.
  logic [DW-1:0] rf_mem [8] = '{default: '0};
  always @(posedge clk) if (bus.rf_write) rf_mem[bus.rf_writenum] <= bus.rf_data_in;
  assign bus.rf_data_out = rf_mem[bus.rf_readnum];

  // Requester state, held until the model says the request was accepted.
  bit            busy   [2];
  bit            r_we   [2];
  bit            r_lock [2];
  logic [AW-1:0] r_addr [2];
  logic [DW-1:0] r_wdata[2];

  assign bus.req       = {busy[1], busy[0]};
  assign bus.req_we    = {r_we[1], r_we[0]};
  assign bus.req_lock  = {r_lock[1], r_lock[0]};
  assign bus.req_addr  = {r_addr[1], r_addr[0]};
  assign bus.req_wdata = {r_wdata[1], r_wdata[0]};

  // Reference model: register contents, lock ownership, whose turn it is.
  logic [DW-1:0] m_mem [8] = '{default: '0};
  bit   m_lock, m_owner, m_fav;
  rsp_t exp_q [2][$];

  logic [1:0]    g_gnt;
  logic [1:0]    g_rspv;
  logic [DW-1:0] g_rspd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s at cycle %0d: actual=%h required=%h", name, cyc, act, req);
    end
  endtask

  task automatic issue(input int i, input bit we, input int addr, input int data, input bit lk);
    busy[i]    = 1'b1;
    r_we[i]    = we;
    r_lock[i]  = lk;
    r_addr[i]  = addr[AW-1:0];
    r_wdata[i] = data[DW-1:0];
  endtask

  task automatic step();
    logic [1:0] pred;
    int w;
    @(negedge clk);
    pred = 2'b00;
    if (!rst_n) begin
      m_lock = 1'b0;
      m_fav  = 1'b0;
    end else if (m_lock && busy[m_owner] && r_lock[m_owner]) begin
      pred[m_owner] = 1'b1;
    end else if (busy[0] && busy[1]) begin
      pred[m_lock ? !m_owner : m_fav] = 1'b1;
    end else begin
      pred = {busy[1], busy[0]};
    end
    g_gnt  = bus.gnt;
    g_rspv = bus.rsp_valid;
    g_rspd = bus.rsp_data;
    chk("gnt", bus.gnt, pred);
    if (pred == 2'b00) begin
      chk("rf_write_idle", bus.rf_write, 0);
      if (rst_n) m_lock = 1'b0;
    end else begin
      w = pred[1] ? 1 : 0;
      chk("rf_write", bus.rf_write, r_we[w]);
      if (r_we[w]) begin
        chk("rf_writenum", bus.rf_writenum, r_addr[w]);
        chk("rf_data_in", bus.rf_data_in, r_wdata[w]);
        m_mem[r_addr[w]] = r_wdata[w];
      end else begin
        chk("rf_readnum", bus.rf_readnum, r_addr[w]);
        exp_q[w].push_back('{cyc + 1, m_mem[r_addr[w]]});
      end
      m_fav   = (w == 0);
      m_lock  = r_lock[w];
      m_owner = (w == 1);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) if (pred[i]) busy[i] = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && (busy[0] || busy[1]); k++) step();
    chk("drain_done", {30'd0, busy[1], busy[0]}, 0);
  endtask

  // Response monitor: every rsp_valid must match the oldest outstanding read.
  initial begin
    rsp_t e;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (!rst_n) begin
          exp_q[i].delete();
          chk($sformatf("rsp_valid%0d_in_reset", i), bus.rsp_valid[i], 0);
        end else if (bus.rsp_valid[i]) begin
          if (exp_q[i].size() == 0) begin
            chk($sformatf("rsp_valid%0d_unexpected", i), bus.rsp_valid[i], 0);
          end else begin
            e = exp_q[i].pop_front();
            chk($sformatf("rsp%0d_cycle", i), cyc, e.cyc);
            chk($sformatf("rsp%0d_data", i), bus.rsp_data, e.data);
          end
        end else if (exp_q[i].size() > 0 && exp_q[i][0].cyc <= cyc) begin
          chk($sformatf("rsp_valid%0d_missing", i), bus.rsp_valid[i], 1);
          void'(exp_q[i].pop_front());
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    busy[0] = 1'b0;
    busy[1] = 1'b0;
    // 1: reset with both requesting, then r0 first
    issue(0, 0, 0, 0, 0);
    issue(1, 0, 1, 0, 0);
    step();
    chk("t1_reset_gnt", g_gnt, 2'b00);
    chk("t1_reset_rspv", g_rspv, 2'b00);
    step();
    rst_n = 1'b1;
    step();
    chk("t1_r0_first", g_gnt, 2'b01);
    drain();

    // 2: simultaneous writes, then read back
    issue(0, 1, 1, 16'h0023, 0);
    issue(1, 1, 2, 16'h00F1, 0);
    step();
    chk("t2_gnt_a", g_gnt, 2'b01);
    step();
    chk("t2_gnt_b", g_gnt, 2'b10);
    issue(0, 0, 1, 0, 0);
    issue(1, 0, 2, 0, 0);
    drain();
    step();
    step();

    // 3: continuous reads alternate
    for (int k = 0; k < 6; k++) begin
      if (!busy[0]) issue(0, 0, 0, 0, 0);
      if (!busy[1]) issue(1, 0, 1, 0, 0);
      step();
      chk("t3_alternate", g_gnt, (k % 2 == 0) ? 2'b01 : 2'b10);
    end
    drain();

    // 4: r1 locks for three cycles while r0 waits
    issue(0, 1, 7, 16'h1234, 0);
    step();
    issue(1, 0, 3, 0, 1);
    issue(0, 0, 4, 0, 0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t4_locked", g_gnt, 2'b10);
      if (k < 2) issue(1, 0, 3, 0, 1);
    end
    step();
    chk("t4_release", g_gnt, 2'b01);
    drain();
    step();

    // 5: write then read the same index on the next cycle
    issue(0, 1, 5, 16'hFFFF, 0);
    step();
    issue(1, 0, 5, 0, 0);
    step();
    step();
    chk("t5_rspv", g_rspv, 2'b10);
    chk("t5_rspd", g_rspd, 16'hFFFF);

    // 6: reset during a lock
    issue(1, 0, 6, 0, 1);
    step();
    issue(1, 0, 6, 0, 1);
    issue(0, 0, 0, 0, 0);
    step();
    chk("t6_locked", g_gnt, 2'b10);
    issue(1, 0, 6, 0, 1);
    rst_n = 1'b0;
    step();
    chk("t6_reset_gnt", g_gnt, 2'b00);
    chk("t6_reset_rspv", g_rspv, 2'b00);
    rst_n = 1'b1;
    step();
    chk("t6_r0_favoured", g_gnt, 2'b01);
    drain();

    // Random traffic against the model
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < 2; i++) begin
        if (!busy[i] && $urandom_range(0, 9) < 6)
          issue(i, 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                int'($urandom_range(0, 65535)), $urandom_range(0, 3) == 0);
      end
      step();
    end
    r_lock[0] = 1'b0;
    r_lock[1] = 1'b0;
    drain();
    step();
    step();
    chk("scoreboard_empty", exp_q[0].size() + exp_q[1].size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
